fifo_stream_out: RTL
====================

// Module: fifo_stream_out
// PURPOSE
//  Read-side adapter placed directly downstream of the synchronous FIFO. Drives the FIFO's
//  rd_en and captures its registered data_out, which is valid the cycle after a granted read.
//  Re-presents that data as a valid/ready stream with full throughput and no data loss under
//  back-pressure. Sits between the FIFO and any stream consumer (UART tx, packetizer, DMA).
// PARAMETERS
//  DATA_WIDTH  8  width of FIFO data and m_data
// PORTS
//  clk          in   1           clock, single domain
//  rst          in   1           synchronous active-high reset
//  fifo_empty   in   1           FIFO empty flag
//  fifo_data    in   DATA_WIDTH  FIFO data_out (valid 1 cycle after granted rd_en)
//  fifo_rd_en   out  1           FIFO read enable
//  m_valid      out  1           stream data valid
//  m_ready      in   1           stream consumer ready
//  m_data       out  DATA_WIDTH  stream data
//  beat_cnt     out  32          handshake count (present only with FIFO_STREAM_OUT_STATS_EN)
// BEHAVIOUR
//  - Clock is clk. Reset is synchronous and active-high on rst, sampled on posedge clk.
//  - Reset: m_valid=0, m_data=0, fifo_rd_en=0, beat_cnt=0; skid buffer occ=0, inflight=0.
//  - Internal skid buffer: 3 entries, circular, with 2-bit wr/rd pointers wrapping 2->0.
//  - occ is the entry count 0..3. inflight is 1 bit, set when a read was granted last cycle.
//  - fifo_rd_en = !rst && !fifo_empty && (occ + inflight < 3).
//    It is combinational and does NOT depend on m_ready.
//  - Credit rule guarantees every in-flight word has a free slot. No data is ever dropped.
//  - inflight <= fifo_rd_en every cycle.
//  - When inflight=1, fifo_data is written to the buffer at that cycle's posedge.
//  - m_valid = (occ != 0), m_data = buffer head; both are driven directly from registers.
//  - Pop on m_valid && m_ready. Push and pop in the same cycle leave occ unchanged.
//  - Latency: fifo_rd_en high in cycle t -> word in buffer end of t+1 -> m_valid in t+2.
//  - Throughput: 1 beat/cycle sustained with m_ready=1 and FIFO non-empty.
//  - Back-pressure: m_ready=0 -> occ fills to 3, then fifo_rd_en stays 0 until a pop.
//  - Stream rule: once m_valid=1, m_valid and m_data hold stable until handshake.
//  - Order: words leave in exact FIFO order. No reordering or duplication.
//  - Empty FIFO: fifo_rd_en=0. Remaining buffered words still drain normally.
//  - Reset mid-operation: buffer and inflight are discarded, m_valid falls the next cycle.
//    The FIFO shares rst and is cleared in the same cycle.
// CONFIGURATION
//  - Macro FIFO_STREAM_OUT_STATS_EN defined:
//    - beat_cnt port exists and increments by 1 on each m_valid && m_ready.
//    - Wraps from 2^32-1 to 0. Cleared by rst.
//  - Undefined: beat_cnt port and counter logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package fifo_pkg:
//    - SKID_DEPTH=3, SKID_PTR_W=2, OCC_W=2, BEAT_CNT_W=32.
//    - Pointer-increment-with-wrap function.
//  - One sub-module, fifo_skid_buf:
//    - 3-entry circular register buffer with push/pop, head output and occ.
//    - Top level owns the credit, inflight and stats logic.
// TESTING
//  1 Single word: FIFO loaded with 0xA5, m_ready=1 -> fifo_rd_en 1 cycle.
//    m_valid high 2 cycles later with m_data=0xA5 for 1 cycle. FIFO ends empty.
//  2 Burst: 16 words 0x00..0x0F, m_ready=1 -> 16 consecutive m_valid beats in order.
//    No bubbles after 2-cycle latency.
//  3 Back-pressure: 8 words, m_ready=0 -> exactly 3 reads then fifo_rd_en=0.
//    m_data holds 0x00. Then m_ready=1 -> remaining 8 beats in order.
//  4 Toggle: m_ready alternates 1/0 over 10 words -> every word delivered once, in order.
//    occ never exceeds 3.
//  5 Reset mid-burst: rst for 1 cycle after 4 of 12 beats -> m_valid=0 next cycle.
//    No further beats occur until new writes.
//  6 Stats (macro on): 20 handshakes -> beat_cnt=20; rst -> beat_cnt=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   SKID_DEPTH  : entries in the skid buffer behind the FIFO read port
//   SKID_PTR_W  : width of skid buffer read/write pointers
//   OCC_W       : width of the skid buffer occupancy count
//   BEAT_CNT_W  : width of the optional handshake counter
//   ptr_inc()   : pointer increment wrapping SKID_DEPTH-1 -> 0
package fifo_pkg;

    localparam int unsigned SKID_DEPTH = 3;
    localparam int unsigned SKID_PTR_W = 2;
    localparam int unsigned OCC_W      = 2;
    localparam int unsigned BEAT_CNT_W = 32;

    function automatic logic [SKID_PTR_W-1:0] ptr_inc(input logic [SKID_PTR_W-1:0] ptr);
        return (ptr == SKID_PTR_W'(SKID_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Three-entry circular register buffer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data into the tail entry
//   push_data  : data to store
//   pop        : discard the head entry (caller guarantees occ != 0)
//   head       : head entry, straight from the storage registers
//   occ        : number of stored entries, 0..3
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_stream_out.sv
// Read-side adapter for the synchronous FIFO: issues fifo_rd_en, captures the
// registered FIFO output one cycle later into a 3-entry skid buffer, and presents
// the buffer head as a valid/ready stream at full throughput without data loss.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (shared with the FIFO)
//   fifo_empty  : FIFO empty flag
//   fifo_data   : FIFO data_out, valid the cycle after a granted read
//   fifo_rd_en  : FIFO read enable (combinational, independent of m_ready)
//   m_valid     : stream valid
//   m_ready     : stream ready
//   m_data      : stream data
//   beat_cnt    : handshake counter, only with FIFO_STREAM_OUT_STATS_EN defined
// Build option: define FIFO_STREAM_OUT_STATS_EN to add beat_cnt.
module fifo_stream_out
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_STREAM_OUT_STATS_EN
    ,
    output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   credit_used;
    logic             pop;

    // A read is only issued when a slot is reserved for it: stored words plus the
    // word already on its way must leave room, so a push never finds the buffer full.
    always_comb begin
        credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
        fifo_rd_en  = !rst && !fifo_empty && (credit_used < (OCC_W + 1)'(SKID_DEPTH));
        inflight_d  = fifo_rd_en;
        m_valid     = (occ != '0);
        pop         = m_valid && m_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (fifo_data),
        .pop        (pop),
        .head       (m_data),
        .occ        (occ)
    );

`ifdef FIFO_STREAM_OUT_STATS_EN
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
